// File: rtl/mem_stage.sv
// Memory-access stage: forwards ALU results, issues loads/stores over a req/ready
// handshake, stalls upstream while waiting, and aborts with a fault pulse on timeout.
module mem_stage #(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [15:0] alu_result_in,
  input  logic [15:0] rs2_data_in,
  input  logic [3:0]  rd_in,
  input  logic        reg_write_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic        mem_to_reg_in,
  output logic        stall_out,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [15:0] dmem_addr,
  output logic [15:0] dmem_wdata,
  input  logic [15:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        wb_valid,
  output logic [15:0] wb_data,
  output logic [3:0]  wb_rd,
  output logic        wb_reg_write,
  output logic        mem_fault
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [3:0]  rd;
    logic        we;
    logic        reg_write;
    logic        mem_to_reg;
  } mreq_t;

  typedef struct packed {
    logic        valid;
    logic [15:0] data;
    logic [3:0]  rd;
    logic        reg_write;
  } wb_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  mreq_t         req_q, req_d;
  wb_t           wb_q, wb_d;
  logic          fault_q, fault_d;

  logic mem_op;
  assign mem_op = mem_read_in | mem_write_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      wb_q    <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      wb_q    <= wb_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    req_d    = req_q;
    wb_d     = wb_q;
    wb_d.valid = 1'b0;
    fault_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (valid_in && mem_op) begin
          req_d.addr       = alu_result_in;
          req_d.wdata      = rs2_data_in;
          req_d.rd         = rd_in;
          req_d.we         = mem_write_in;
          req_d.reg_write  = reg_write_in;
          req_d.mem_to_reg = mem_to_reg_in;
          cnt_d            = '0;
          state_d          = S_WAIT;
        end else if (valid_in) begin
          wb_d.valid     = 1'b1;
          wb_d.data      = alu_result_in;
          wb_d.rd        = rd_in;
          wb_d.reg_write = reg_write_in;
        end
      end
      S_WAIT: begin
        if (dmem_ready) begin
          state_d        = S_IDLE;
          wb_d.valid     = 1'b1;
          wb_d.rd        = req_q.rd;
          wb_d.reg_write = req_q.reg_write;
          wb_d.data      = (!req_q.we && req_q.mem_to_reg) ? dmem_rdata : req_q.addr;
        end else begin
          // cnt_q counts earlier ready-less cycles, so this is the MAX_WAIT-th one
          if (cnt_q == CW'(MAX_WAIT - 1)) begin
            state_d = S_IDLE;
            fault_d = 1'b1;
          end
          if (cnt_q != CW'(MAX_WAIT)) cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign stall_out    = (state_q == S_WAIT);
  assign dmem_req     = (state_q == S_WAIT);
  assign dmem_we      = req_q.we;
  assign dmem_addr    = req_q.addr;
  assign dmem_wdata   = req_q.wdata;
  assign wb_valid     = wb_q.valid;
  assign wb_data      = wb_q.data;
  assign wb_rd        = wb_q.rd;
  assign wb_reg_write = wb_q.reg_write;
  assign mem_fault    = fault_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus a randomized
// instruction stream compared against a transaction-level reference model.
module tb_mem_stage;
  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_in = 1'b0;
  logic [15:0] alu_result_in = '0, rs2_data_in = '0;
  logic [3:0]  rd_in = '0;
  logic        reg_write_in = 1'b0, mem_read_in = 1'b0, mem_write_in = 1'b0, mem_to_reg_in = 1'b0;
  logic        stall_out, dmem_req, dmem_we;
  logic [15:0] dmem_addr, dmem_wdata;
  logic [15:0] dmem_rdata = '0;
  logic        dmem_ready = 1'b0;
  logic        wb_valid, wb_reg_write, mem_fault;
  logic [15:0] wb_data;
  logic [3:0]  wb_rd;

  int total = 0;
  int bad = 0;

  mem_stage #(.MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .alu_result_in(alu_result_in),
    .rs2_data_in(rs2_data_in), .rd_in(rd_in), .reg_write_in(reg_write_in),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .mem_to_reg_in(mem_to_reg_in),
    .stall_out(stall_out), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .mem_fault(mem_fault)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [15:0] alu, input logic [15:0] wd,
                        input logic [3:0] rd, input logic rw, input logic mr,
                        input logic mw, input logic m2r);
    valid_in = v; alu_result_in = alu; rs2_data_in = wd; rd_in = rd;
    reg_write_in = rw; mem_read_in = mr; mem_write_in = mw; mem_to_reg_in = m2r;
  endtask

  // Reference: value the WB stage should receive for one retired instruction
  function automatic logic [15:0] ref_wb_data(input logic mr, input logic mw, input logic m2r,
                                              input logic [15:0] alu, input logic [15:0] rdata);
    if (mr && !mw && m2r) return rdata;
    return alu;
  endfunction

  task automatic test_reset();
    set_in(1, 16'h1111, 16'h2222, 4'd9, 1, 1, 0, 1);
    step();
    total++; if (dmem_req !== 1'b1) begin bad++; $display("FAIL reset_pre_req got=%b exp=1", dmem_req); end
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    #3 rst = 1'b1;
    #1;
    total++; if ({dmem_req, stall_out, dmem_we, wb_valid, wb_reg_write, mem_fault} !== 6'b0)
      begin bad++; $display("FAIL reset_ctl got=%b exp=000000", {dmem_req, stall_out, dmem_we, wb_valid, wb_reg_write, mem_fault}); end
    total++; if ({dmem_addr, dmem_wdata, wb_data, wb_rd} !== 52'h0)
      begin bad++; $display("FAIL reset_data got=%h exp=0", {dmem_addr, dmem_wdata, wb_data, wb_rd}); end
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      total++; if ({wb_valid, dmem_req, mem_fault} !== 3'b0)
        begin bad++; $display("FAIL reset_idle cyc=%0d got=%b exp=000", i, {wb_valid, dmem_req, mem_fault}); end
    end
  endtask

  task automatic test_alu_pass();
    logic [15:0] vals[3] = '{16'h0011, 16'h0022, 16'h0033};
    for (int i = 0; i < 3; i++) begin
      set_in(1, vals[i], 16'h0, 4'(i + 1), 1, 0, 0, 0);
      step();
      total++; if ({wb_valid, wb_data, wb_rd, wb_reg_write, stall_out} !== {1'b1, vals[i], 4'(i + 1), 1'b1, 1'b0})
        begin bad++; $display("FAIL alu_pass%0d got v=%b d=%h rd=%0d rw=%b st=%b exp d=%h rd=%0d", i, wb_valid, wb_data, wb_rd, wb_reg_write, stall_out, vals[i], i + 1); end
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    total++; if (wb_valid !== 1'b0 || wb_data !== 16'h0033) begin bad++; $display("FAIL alu_hold got v=%b d=%h exp v=0 d=0033", wb_valid, wb_data); end
  endtask

  task automatic test_load();
    int req_cycles = 0;
    set_in(1, 16'h1234, 16'h0, 4'd5, 1, 1, 0, 1);
    step();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    for (int j = 1; j <= 3; j++) begin
      if (dmem_req === 1'b1) req_cycles++;
      total++; if ({stall_out, dmem_we, dmem_addr} !== {1'b1, 1'b0, 16'h1234})
        begin bad++; $display("FAIL load_wait%0d got st=%b we=%b a=%h exp st=1 we=0 a=1234", j, stall_out, dmem_we, dmem_addr); end
      if (j == 3) begin dmem_ready = 1'b1; dmem_rdata = 16'hBEEF; end
      step();
    end
    dmem_ready = 1'b0;
    if (dmem_req === 1'b1) req_cycles++;
    total++; if ({wb_valid, wb_data, wb_rd, wb_reg_write, stall_out} !== {1'b1, 16'hBEEF, 4'd5, 1'b1, 1'b0})
      begin bad++; $display("FAIL load_wb got v=%b d=%h rd=%0d rw=%b st=%b exp v=1 d=beef rd=5 rw=1 st=0", wb_valid, wb_data, wb_rd, wb_reg_write, stall_out); end
    step();
    if (dmem_req === 1'b1) req_cycles++;
    total++; if (req_cycles !== 3) begin bad++; $display("FAIL load_req_cycles got=%0d exp=3", req_cycles); end
    total++; if (wb_valid !== 1'b0 || wb_data !== 16'hBEEF) begin bad++; $display("FAIL load_hold got v=%b d=%h exp v=0 d=beef", wb_valid, wb_data); end
  endtask

  task automatic test_store_held();
    set_in(1, 16'h0040, 16'hA5A5, 4'd3, 0, 0, 1, 0);
    step();
    total++; if ({dmem_req, dmem_we, dmem_addr, dmem_wdata} !== {1'b1, 1'b1, 16'h0040, 16'hA5A5})
      begin bad++; $display("FAIL store_req got r=%b we=%b a=%h wd=%h exp r=1 we=1 a=0040 wd=a5a5", dmem_req, dmem_we, dmem_addr, dmem_wdata); end
    set_in(1, 16'h0077, 16'h0, 4'd7, 1, 0, 0, 0);
    dmem_ready = 1'b1;
    step();
    dmem_ready = 1'b0;
    total++; if ({wb_valid, wb_reg_write, wb_data, stall_out, dmem_req} !== {1'b1, 1'b0, 16'h0040, 1'b0, 1'b0})
      begin bad++; $display("FAIL store_wb got v=%b rw=%b d=%h st=%b r=%b exp v=1 rw=0 d=0040 st=0 r=0", wb_valid, wb_reg_write, wb_data, stall_out, dmem_req); end
    step();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    total++; if ({wb_valid, wb_data, wb_rd, wb_reg_write} !== {1'b1, 16'h0077, 4'd7, 1'b1})
      begin bad++; $display("FAIL store_held_next got v=%b d=%h rd=%0d exp v=1 d=0077 rd=7", wb_valid, wb_data, wb_rd); end
    step();
  endtask

  task automatic test_timeout();
    for (int rep = 0; rep < 2; rep++) begin
      set_in(1, 16'h0100, 16'h0, 4'd4, 1, 1, 0, 1);
      step();
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      for (int j = 1; j <= MW; j++) begin
        total++; if ({stall_out, mem_fault} !== 2'b10) begin bad++; $display("FAIL timeout%0d_wait%0d got st=%b f=%b exp st=1 f=0", rep, j, stall_out, mem_fault); end
        if (rep == 1 && j == MW) begin dmem_ready = 1'b1; dmem_rdata = 16'h5A5A; end
        step();
      end
      dmem_ready = 1'b0;
      if (rep == 0) begin
        total++; if ({mem_fault, wb_valid, stall_out, dmem_req} !== 4'b1000)
          begin bad++; $display("FAIL timeout_fault got f=%b v=%b st=%b r=%b exp f=1 v=0 st=0 r=0", mem_fault, wb_valid, stall_out, dmem_req); end
      end else begin
        total++; if ({mem_fault, wb_valid, wb_data} !== {1'b0, 1'b1, 16'h5A5A})
          begin bad++; $display("FAIL timeout_race got f=%b v=%b d=%h exp f=0 v=1 d=5a5a", mem_fault, wb_valid, wb_data); end
      end
      set_in(1, 16'h0abc, 16'h0, 4'd2, 1, 0, 0, 0);
      step();
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      total++; if ({mem_fault, wb_valid, wb_data} !== {1'b0, 1'b1, 16'h0abc})
        begin bad++; $display("FAIL timeout%0d_next got f=%b v=%b d=%h exp f=0 v=1 d=0abc", rep, mem_fault, wb_valid, wb_data); end
    end
    step();
  endtask

  task automatic test_both_flags();
    set_in(1, 16'h0008, 16'h1357, 4'd6, 1, 1, 1, 1);
    step();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    total++; if ({dmem_we, dmem_addr} !== {1'b1, 16'h0008}) begin bad++; $display("FAIL both_we got we=%b a=%h exp we=1 a=0008", dmem_we, dmem_addr); end
    dmem_ready = 1'b1; dmem_rdata = 16'hFFFF;
    step();
    dmem_ready = 1'b0;
    total++; if ({wb_valid, wb_data} !== {1'b1, 16'h0008}) begin bad++; $display("FAIL both_wb got v=%b d=%h exp v=1 d=0008", wb_valid, wb_data); end
    step();
  endtask

  task automatic test_random();
    logic [15:0] last_d = wb_data;
    logic [3:0]  last_rd = wb_rd;
    for (int n = 0; n < 60; n++) begin
      logic v, mr, mw, m2r, rw;
      logic [15:0] alu, wd, rdata;
      logic [3:0] rd;
      int lat;
      v = ($urandom_range(0, 4) != 0);
      mr = $urandom_range(0, 1); mw = ($urandom_range(0, 3) == 0); m2r = $urandom_range(0, 1);
      rw = $urandom_range(0, 1); alu = 16'($urandom); wd = 16'($urandom); rd = 4'($urandom);
      rdata = 16'($urandom); lat = $urandom_range(1, MW + 1);
      set_in(v, alu, wd, rd, rw, mr, mw, m2r);
      step();
      set_in(0, 16'($urandom), 16'($urandom), 4'($urandom), 1, 1, 1, 1);
      if (!v) begin
        total++; if ({wb_valid, stall_out, wb_data} !== {1'b0, 1'b0, last_d})
          begin bad++; $display("FAIL rnd%0d_idle got v=%b st=%b d=%h exp v=0 st=0 d=%h", n, wb_valid, stall_out, wb_data, last_d); end
      end else if (!(mr || mw)) begin
        total++; if ({wb_valid, wb_data, wb_rd, wb_reg_write, stall_out} !== {1'b1, alu, rd, rw, 1'b0})
          begin bad++; $display("FAIL rnd%0d_alu got v=%b d=%h rd=%0d exp d=%h rd=%0d", n, wb_valid, wb_data, wb_rd, alu, rd); end
        last_d = alu; last_rd = rd;
      end else begin
        for (int j = 1; j <= ((lat < MW) ? lat : MW); j++) begin
          total++; if ({dmem_req, stall_out, dmem_we, dmem_addr, dmem_wdata} !== {1'b1, 1'b1, mw, alu, wd})
            begin bad++; $display("FAIL rnd%0d_wait%0d got r=%b we=%b a=%h wd=%h exp we=%b a=%h wd=%h", n, j, dmem_req, dmem_we, dmem_addr, dmem_wdata, mw, alu, wd); end
          if (j == lat) begin dmem_ready = 1'b1; dmem_rdata = rdata; end
          step();
          dmem_ready = 1'b0; dmem_rdata = 16'($urandom);
        end
        if (lat <= MW) begin
          total++; if ({wb_valid, mem_fault, dmem_req, wb_data, wb_rd, wb_reg_write} !== {1'b1, 1'b0, 1'b0, ref_wb_data(mr, mw, m2r, alu, rdata), rd, rw})
            begin bad++; $display("FAIL rnd%0d_mem got v=%b f=%b d=%h rd=%0d exp d=%h rd=%0d", n, wb_valid, mem_fault, wb_data, wb_rd, ref_wb_data(mr, mw, m2r, alu, rdata), rd); end
          last_d = ref_wb_data(mr, mw, m2r, alu, rdata); last_rd = rd;
        end else begin
          total++; if ({wb_valid, mem_fault, dmem_req, wb_data, wb_rd} !== {1'b0, 1'b1, 1'b0, last_d, last_rd})
            begin bad++; $display("FAIL rnd%0d_tmo got v=%b f=%b d=%h exp v=0 f=1 d=%h", n, wb_valid, mem_fault, wb_data, last_d); end
        end
      end
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    step();
  endtask

  initial begin
    #2 rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    test_reset();
    test_alu_pass();
    test_load();
    test_store_held();
    test_timeout();
    test_both_flags();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 16-bit pipeline. It sits directly downstream of the EX2 stage and consumes its ALU result, store data, destination register and control flags. Loads and stores are issued to the data memory over a req/ready handshake, with the upstream pipeline stalled until the memory responds. A registered write-back bundle is produced for the WB stage, and a bounded wait counter turns a hung memory into a fault pulse instead of a deadlock.

## Interface
- MAX_WAIT, 15, max cycles in WAIT without dmem_ready before abort; legal range ≥1
- clk  in  1  single clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- valid_in  in  1  EX2 bundle valid this cycle
- alu_result_in  in  16  ALU result / effective address
- rs2_data_in  in  16  store data
- rd_in  in  4  destination register
- reg_write_in, mem_read_in, mem_write_in, mem_to_reg_in  in  1 each  control flags from EX2
- stall_out  out  1  upstream must hold its bundle
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = store, 0 = load
- dmem_addr  out  16  request address
- dmem_wdata  out  16  store data
- dmem_rdata  in  16  load data, valid when dmem_ready=1
- dmem_ready  in  1  memory completes the current request
- wb_valid  out  1  one-cycle pulse per retired instruction
- wb_data  out  16  write-back value
- wb_rd  out  4  write-back register
- wb_reg_write  out  1  register-file write enable
- mem_fault  out  1  one-cycle pulse on timeout

## Operation
- FSM states: IDLE and WAIT.
- IDLE, valid_in=1, mem op = mem_read_in|mem_write_in = 0:
  - Retire next edge: wb_valid=1, wb_data=alu_result_in, wb_rd=rd_in, wb_reg_write=reg_write_in.
  - Stay in IDLE.
- IDLE, valid_in=1, mem op = 1:
  - Latch addr, wdata, rd, reg_write and mem_to_reg.
  - dmem_we = mem_write_in. Write has priority if both flags are set.
  - Clear the wait counter and go to WAIT. No wb_valid this cycle.
- IDLE, valid_in=0: nothing happens; wb_valid=0.
- WAIT:
  - dmem_req=1; dmem_addr, dmem_we and dmem_wdata are held stable from the latched values.
  - stall_out=1. Inputs are ignored.
- WAIT, dmem_ready=1:
  - Go to IDLE.
  - Next edge: wb_valid=1, wb_rd = latched rd, wb_reg_write = latched reg_write.
  - wb_data = dmem_rdata if this is a load with mem_to_reg=1, otherwise the latched address.
- WAIT, dmem_ready=0: counter increments.
- WAIT, counter == MAX_WAIT and dmem_ready=0:
  - Go to IDLE; mem_fault=1 for one cycle; wb_valid=0. The instruction is dropped.
- Simultaneous ready and timeout: ready wins and the instruction retires normally.
- Counter width is clog2(MAX_WAIT+1). It saturates and never wraps.
- wb_data, wb_rd and wb_reg_write hold their last values between wb_valid pulses.
- Reset values:
  - state=IDLE, counter=0.
  - dmem_req, dmem_we, stall_out, wb_valid, wb_reg_write, mem_fault = 0.
  - dmem_addr, dmem_wdata, wb_data = 16'h0000; wb_rd = 4'h0.
- Reset asserted mid-WAIT: the transaction is abandoned. dmem_req drops immediately (asynchronously) and no wb_valid or mem_fault is produced.

## Timing
- Non-memory instruction: accepted at edge N, wb_valid high in cycle N+1. Throughput 1/cycle.
- Memory instruction:
  - Accepted at edge N; dmem_req high from cycle N+1.
  - If ready is sampled at edge N+k (k≥1), wb_valid is high in cycle N+k+1.
  - Minimum load/store latency is 2 cycles.
- stall_out is registered state (high exactly while in WAIT). It is low in the cycle after completion, so the held upstream bundle is accepted that cycle.
- dmem_req deasserts at the same edge where dmem_ready is sampled high. Memory must not see a second request for one transaction.
- Timeout: mem_fault is high in the cycle after the MAX_WAIT-th ready-less WAIT cycle.

## Test plan
- **Reset:** assert rst mid-cycle with ready held low → all outputs go 0 asynchronously. Release, then idle 5 cycles → no wb_valid and no dmem_req.
- **ALU pass-through:** 3 back-to-back non-memory bundles (alu 16'h0011/0022/0033, rd 1/2/3, reg_write=1) → wb_valid on 3 consecutive cycles with matching data/rd, and stall_out never high.
- **Load with 3-cycle memory:** addr 16'h1234, mem_read=1, mem_to_reg=1, rd=5; ready pulses on the 3rd WAIT cycle with rdata 16'hBEEF → stall_out high for 3 cycles, then wb_data=16'hBEEF, wb_rd=5, wb_reg_write=1. dmem_req is high for exactly 3 cycles.
- **Store, then next instruction held upstream:** store addr 16'h0040, wdata 16'hA5A5; ready on 1st WAIT cycle → dmem_we=1 with stable addr/wdata, wb_reg_write=0. The held next ALU bundle retires on the following cycle.
- **Timeout:** with MAX_WAIT=4, issue a load and never assert ready → mem_fault pulses once, no wb_valid, state returns to IDLE and the next bundle is accepted. Repeat with ready arriving on the same cycle as the timeout → normal retire and no fault.
- **Both read and write set:** addr 16'h0008 → dmem_we=1 (write priority), wb_data=16'h0008.
